// File: rtl/op_stream_decoder_pkg.sv
// Shared opcode and data1 constants for the command byte-stream decoder.
package op_stream_decoder_pkg;

  localparam logic [7:0] OP_ATTEN     = 8'hC4;
  localparam logic [7:0] OP_LED       = 8'hC5;
  localparam logic [7:0] OP_SAMPLE    = 8'hC7;
  localparam logic [7:0] OP_END_11K   = 8'h07;
  localparam logic [7:0] OP_START_11K = 8'h0F;
  localparam logic [7:0] OP_END_22K   = 8'h17;
  localparam logic [7:0] OP_START_22K = 8'h1F;
  localparam logic [7:0] OP_ALL_ONES  = 8'hFF;

  localparam logic [7:0] D1_POWER_ON_R1 = 8'hEF;
  localparam logic [7:0] D1_LED_UPDATE  = 8'h00;

  localparam int unsigned PKT_W = 24;

endpackage

// File: rtl/op_stream_decoder_assembler.sv
// Frames the serial byte stream into 3-byte {opcode, data1, data2} packets.
// Handshake: in_valid_i accepts in_byte_i on every rising edge; there is no ready, the block never stalls.
module op_byte_assembler
  import op_stream_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte_i,
  input  logic             in_valid_i,
  input  logic             in_start_i,
  output logic [PKT_W-1:0] packet_o,
  output logic             packet_valid_o,
  output logic             err_frame_o
);

  logic [1:0] cnt_q, cnt_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic       err_q, err_d;

  // packet_valid_o strobes in the cycle the third byte is presented so the
  // top can register every decode result on that same edge.
  always_comb begin
    cnt_d          = cnt_q;
    b0_d           = b0_q;
    b1_d           = b1_q;
    err_d          = 1'b0;
    packet_valid_o = 1'b0;
    packet_o       = {b0_q, b1_q, in_byte_i};
    if (in_valid_i) begin
      if (in_start_i) begin
        err_d = (cnt_q != 2'd0);
        b0_d  = in_byte_i;
        cnt_d = 2'd1;
      end else begin
        case (cnt_q)
          2'd0: err_d = 1'b1;
          2'd1: begin
            b1_d  = in_byte_i;
            cnt_d = 2'd2;
          end
          2'd2: begin
            packet_valid_o = 1'b1;
            cnt_d          = 2'd0;
          end
          default: cnt_d = 2'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      b0_q  <= 8'h00;
      b1_q  <= 8'h00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      err_q <= err_d;
    end
  end

  assign err_frame_o = err_q;

endmodule

// File: rtl/op_stream_decoder.sv
// Decodes framed command packets into audio stream control, sample delivery,
// attenuation registers and event/error pulses; every output is a register.
module op_stream_decoder
  import op_stream_decoder_pkg::*;
#(
  parameter int NUM_ATTEN_CH = 2,
  parameter int SAMPLE_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  input  logic                      in_start,
  output logic                      sample_valid,
  output logic [15:0]               sample_data,
  output logic                      audio_start,
  output logic                      audio_end,
  output logic                      led_update,
  output logic                      power_on_r1,
  output logic                      all_ones,
  output logic                      audio_active,
  output logic                      audio_22khz,
  output logic [NUM_ATTEN_CH*8-1:0] atten,
  output logic [SAMPLE_CNT_W-1:0]   sample_count,
  output logic                      err_frame,
  output logic                      err_sample
);

  logic [PKT_W-1:0] packet;
  logic             packet_valid;
  logic [7:0]       opcode, data1, data2;

  op_byte_assembler u_assembler (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_byte_i      (in_byte),
    .in_valid_i     (in_valid),
    .in_start_i     (in_start),
    .packet_o       (packet),
    .packet_valid_o (packet_valid),
    .err_frame_o    (err_frame)
  );

  assign {opcode, data1, data2} = packet;

  logic                      sample_valid_q, sample_valid_d;
  logic [15:0]               sample_data_q, sample_data_d;
  logic                      audio_start_q, audio_start_d;
  logic                      audio_end_q, audio_end_d;
  logic                      led_update_q, led_update_d;
  logic                      power_on_r1_q, power_on_r1_d;
  logic                      all_ones_q, all_ones_d;
  logic                      audio_active_q, audio_active_d;
  logic                      audio_22khz_q, audio_22khz_d;
  logic [NUM_ATTEN_CH*8-1:0] atten_q, atten_d;
  logic [SAMPLE_CNT_W-1:0]   sample_count_q, sample_count_d;
  logic                      err_sample_q, err_sample_d;

  always_comb begin
    sample_valid_d = 1'b0;
    audio_start_d  = 1'b0;
    audio_end_d    = 1'b0;
    led_update_d   = 1'b0;
    power_on_r1_d  = 1'b0;
    all_ones_d     = 1'b0;
    err_sample_d   = 1'b0;
    sample_data_d  = sample_data_q;
    audio_active_d = audio_active_q;
    audio_22khz_d  = audio_22khz_q;
    atten_d        = atten_q;
    sample_count_d = sample_count_q;
    if (packet_valid) begin
      case (opcode)
        OP_LED: begin
          if (data1 == D1_POWER_ON_R1)     power_on_r1_d = 1'b1;
          else if (data1 == D1_LED_UPDATE) led_update_d  = 1'b1;
        end
        OP_ATTEN: begin
          // Out-of-range channel selects are silently ignored.
          if (data2[7:4] == 4'h0 && int'(data2[3:0]) < NUM_ATTEN_CH) begin
            for (int i = 0; i < NUM_ATTEN_CH; i++) begin
              if (int'(data2[3:0]) == i) atten_d[i*8 +: 8] = data1;
            end
          end
        end
        OP_START_11K, OP_START_22K: begin
          audio_start_d  = 1'b1;
          audio_active_d = 1'b1;
          audio_22khz_d  = (opcode == OP_START_22K);
          sample_count_d = '0;
        end
        OP_END_11K, OP_END_22K: begin
          audio_end_d    = 1'b1;
          audio_active_d = 1'b0;
        end
        OP_SAMPLE: begin
          if (audio_active_q) begin
            sample_valid_d = 1'b1;
            sample_data_d  = {data1, data2};
            if (sample_count_q != {SAMPLE_CNT_W{1'b1}})
              sample_count_d = sample_count_q + SAMPLE_CNT_W'(1);
          end else begin
            err_sample_d = 1'b1;
          end
        end
        OP_ALL_ONES: begin
          all_ones_d     = 1'b1;
          audio_active_d = 1'b0;
          audio_22khz_d  = 1'b0;
          sample_count_d = '0;
          atten_d        = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid_q <= 1'b0;
      sample_data_q  <= 16'h0000;
      audio_start_q  <= 1'b0;
      audio_end_q    <= 1'b0;
      led_update_q   <= 1'b0;
      power_on_r1_q  <= 1'b0;
      all_ones_q     <= 1'b0;
      audio_active_q <= 1'b0;
      audio_22khz_q  <= 1'b0;
      atten_q        <= '0;
      sample_count_q <= '0;
      err_sample_q   <= 1'b0;
    end else begin
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      audio_start_q  <= audio_start_d;
      audio_end_q    <= audio_end_d;
      led_update_q   <= led_update_d;
      power_on_r1_q  <= power_on_r1_d;
      all_ones_q     <= all_ones_d;
      audio_active_q <= audio_active_d;
      audio_22khz_q  <= audio_22khz_d;
      atten_q        <= atten_d;
      sample_count_q <= sample_count_d;
      err_sample_q   <= err_sample_d;
    end
  end

  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign audio_start  = audio_start_q;
  assign audio_end    = audio_end_q;
  assign led_update   = led_update_q;
  assign power_on_r1  = power_on_r1_q;
  assign all_ones     = all_ones_q;
  assign audio_active = audio_active_q;
  assign audio_22khz  = audio_22khz_q;
  assign atten        = atten_q;
  assign sample_count = sample_count_q;
  assign err_sample   = err_sample_q;

endmodule

// File: tb/tb_op_stream_decoder.sv
// Directed bench for op_stream_decoder with 2 attenuation channels and a 2-bit sample counter.
module tb_op_stream_decoder;

  localparam int NCH = 2;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     in_byte;
  logic           in_valid;
  logic           in_start;
  logic           sample_valid;
  logic [15:0]    sample_data;
  logic           audio_start, audio_end, led_update, power_on_r1, all_ones;
  logic           audio_active, audio_22khz;
  logic [NCH*8-1:0] atten;
  logic [CW-1:0]  sample_count;
  logic           err_frame, err_sample;

  int checks = 0;
  int errors = 0;

  logic [43:0] all_out;
  assign all_out = {sample_valid, sample_data, audio_start, audio_end, led_update,
                    power_on_r1, all_ones, audio_active, audio_22khz, atten,
                    sample_count, err_frame, err_sample};

  op_stream_decoder #(.NUM_ATTEN_CH(NCH), .SAMPLE_CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_start     (in_start),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .audio_start  (audio_start),
    .audio_end    (audio_end),
    .led_update   (led_update),
    .power_on_r1  (power_on_r1),
    .all_ones     (all_ones),
    .audio_active (audio_active),
    .audio_22khz  (audio_22khz),
    .atten        (atten),
    .sample_count (sample_count),
    .err_frame    (err_frame),
    .err_sample   (err_sample)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Driver tasks: each byte occupies one active cycle followed by one idle
  // cycle; on return the edge that accepted the byte has just passed.
  task automatic send_byte(input logic [7:0] b, input logic s);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    in_start = s;
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; in_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== 44'h0) begin
      errors++; $display("FAIL reset_outputs actual=%h required=0", all_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_audio_start();
    send_pkt(8'h1F, 8'h00, 8'h00);
    checks++;
    if ({audio_start, audio_active, audio_22khz} !== 3'b111) begin
      errors++; $display("FAIL start22 actual=%b required=111", {audio_start, audio_active, audio_22khz});
    end
    @(negedge clk);
    checks++;
    if ({audio_start, audio_active} !== 2'b01) begin
      errors++; $display("FAIL start_pulse_width actual=%b required=01", {audio_start, audio_active});
    end
  endtask

  task automatic test_sample();
    send_pkt(8'h0F, 8'h00, 8'h00);
    checks++;
    if ({audio_start, audio_active, audio_22khz, sample_count} !== 5'b110_00) begin
      errors++; $display("FAIL start11 actual=%b required=11000", {audio_start, audio_active, audio_22khz, sample_count});
    end
    send_pkt(8'hC7, 8'h12, 8'h34);
    checks++;
    if ({sample_valid, sample_data, sample_count} !== {1'b1, 16'h1234, 2'd1}) begin
      errors++; $display("FAIL sample1 actual=%b/%h/%0d required=1/1234/1", sample_valid, sample_data, sample_count);
    end
    send_pkt(8'h07, 8'h00, 8'h00);
    checks++;
    if ({audio_end, audio_active, sample_valid} !== 3'b100) begin
      errors++; $display("FAIL end actual=%b required=100", {audio_end, audio_active, sample_valid});
    end
  endtask

  task automatic test_atten();
    send_pkt(8'hC4, 8'h5A, 8'h01);
    checks++;
    if (atten !== 16'h5A00) begin
      errors++; $display("FAIL atten_ch1 actual=%h required=5a00", atten);
    end
    send_pkt(8'hC4, 8'h77, 8'h02);
    checks++;
    if (atten !== 16'h5A00) begin
      errors++; $display("FAIL atten_range actual=%h required=5a00", atten);
    end
    send_pkt(8'hC4, 8'h33, 8'h10);
    checks++;
    if (atten !== 16'h5A00) begin
      errors++; $display("FAIL atten_hi_nibble actual=%h required=5a00", atten);
    end
    send_pkt(8'hC4, 8'h3C, 8'h00);
    checks++;
    if (atten !== 16'h5A3C) begin
      errors++; $display("FAIL atten_ch0 actual=%h required=5a3c", atten);
    end
  endtask

  task automatic test_framing();
    send_byte(8'hC5, 1'b1);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hC5, 1'b1);
    checks++;
    if ({err_frame, power_on_r1} !== 2'b10) begin
      errors++; $display("FAIL frame_restart actual=%b required=10", {err_frame, power_on_r1});
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h99, 1'b0);
    checks++;
    if ({led_update, power_on_r1, err_frame} !== 3'b100) begin
      errors++; $display("FAIL led_update actual=%b required=100", {led_update, power_on_r1, err_frame});
    end
    send_byte(8'h33, 1'b0);
    checks++;
    if (err_frame !== 1'b1) begin
      errors++; $display("FAIL stray_byte actual=%b required=1", err_frame);
    end
    send_pkt(8'hC5, 8'hEF, 8'h00);
    checks++;
    if ({power_on_r1, led_update, err_frame} !== 3'b100) begin
      errors++; $display("FAIL power_on actual=%b required=100", {power_on_r1, led_update, err_frame});
    end
    send_pkt(8'hC5, 8'h12, 8'h00);
    checks++;
    if ({power_on_r1, led_update} !== 2'b00) begin
      errors++; $display("FAIL c5_other actual=%b required=00", {power_on_r1, led_update});
    end
  endtask

  task automatic test_inactive_sample();
    send_pkt(8'hC7, 8'hAA, 8'hBB);
    checks++;
    if ({err_sample, sample_valid, sample_data} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++; $display("FAIL inactive_sample actual=%b/%b/%h required=1/0/1234", err_sample, sample_valid, sample_data);
    end
  endtask

  task automatic test_all_ones();
    send_pkt(8'hFF, 8'hFF, 8'hFF);
    checks++;
    if ({all_ones, atten, audio_active} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL all_ones actual=%b/%h/%b required=1/0000/0", all_ones, atten, audio_active);
    end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    send_pkt(8'h1F, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      send_pkt(8'hC7, 8'(i), 8'hA0);
      checks++;
      if ({sample_valid, sample_count, sample_data} !== {1'b1, exp_cnt[i], 8'(i), 8'hA0}) begin
        errors++; $display("FAIL saturate[%0d] actual=%b/%0d/%h required=1/%0d/%02hA0",
                           i, sample_valid, sample_count, sample_data, exp_cnt[i], 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hC4, 1'b1);
    send_byte(8'h11, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 44'h0) begin
      errors++; $display("FAIL async_reset actual=%h required=0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h22, 1'b0);
    checks++;
    if (err_frame !== 1'b1) begin
      errors++; $display("FAIL post_reset_needs_start actual=%b required=1", err_frame);
    end
    send_pkt(8'hC4, 8'h66, 8'h00);
    checks++;
    if ({atten, err_frame} !== {16'h0066, 1'b0}) begin
      errors++; $display("FAIL post_reset_pkt actual=%h/%b required=0066/0", atten, err_frame);
    end
  endtask

  initial begin
    test_reset();
    test_audio_start();
    test_sample();
    test_atten();
    test_framing();
    test_inactive_sample();
    test_all_ones();
    test_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_stream_decoder.md
OP_STREAM_DECODER -- requirements
Module: op_stream_decoder

Interface
REQ-001 SHALL have parameter NUM_ATTEN_CH, default 2: number of attenuation channels, range 1..16.
REQ-002 SHALL have parameter SAMPLE_CNT_W, default 16: width of the audio sample counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register changes only on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_byte, input, 8 bits: serial command byte, first byte of a packet is the opcode.
REQ-006 SHALL have port in_valid, input, 1 bit: in_byte is accepted this cycle; the block is always ready.
REQ-007 SHALL have port in_start, input, 1 bit: qualified by in_valid; marks the first byte of a packet.
REQ-008 SHALL have port sample_valid, output, 1 bit: one-cycle pulse, sample_data holds a new audio sample.
REQ-009 SHALL have port sample_data, output, 16 bits: data1 concatenated with data2 of the last audio sample packet.
REQ-010 SHALL have ports audio_start, audio_end, led_update, power_on_r1, all_ones, outputs, 1 bit each: one-cycle event pulses.
REQ-011 SHALL have ports audio_active and audio_22khz, outputs, 1 bit each: sticky mode state.
REQ-012 SHALL have port atten, output, NUM_ATTEN_CH x 8 bits: attenuation registers, channel 0 in the least-significant byte.
REQ-013 SHALL have port sample_count, output, SAMPLE_CNT_W bits: count of accepted samples in the current stream.
REQ-014 SHALL have ports err_frame and err_sample, outputs, 1 bit each: one-cycle error pulses.

Function
REQ-015 SHALL assemble three accepted bytes, MSB first, into {opcode, data1, data2} using a 2-bit byte counter.
REQ-016 SHALL load the byte with in_valid&in_start as byte 0; if the counter was nonzero, the partial packet is dropped and err_frame pulses the next cycle.
REQ-017 SHALL ignore bytes arriving with in_valid while the counter is 0 and in_start is 0, and pulse err_frame for each such byte.
REQ-018 SHALL assert every decode output exactly one cycle after the third byte is accepted, and SHALL wrap the counter to 0 at that byte.
REQ-019 SHALL decode opcode 0xC5 with data1 0xEF as power_on_r1, and 0xC5 with data1 0x00 as led_update; any other 0xC5 packet produces no event.
REQ-020 SHALL decode opcode 0xC4 as an attenuation write when data2[7:4]==0 and data2[3:0] < NUM_ATTEN_CH: atten[data2[3:0]] <= data1; any other 0xC4 packet is ignored.
REQ-021 SHALL handle 0x0F / 0x1F as follows: pulse audio_start; set audio_active=1; set audio_22khz to 0 for 0x0F and 1 for 0x1F; clear sample_count. A start while already active restarts the stream.
REQ-022 SHALL handle 0x07 / 0x17 as follows: pulse audio_end; clear audio_active; keep audio_22khz. An end while inactive still pulses audio_end.
REQ-023 SHALL handle 0xC7 while audio_active as follows: pulse sample_valid; sample_data <= {data1, data2}; increment sample_count, saturating at all ones.
REQ-024 SHALL handle 0xC7 while inactive as follows: drop the packet; pulse err_sample; leave sample_data unchanged.
REQ-025 SHALL handle opcode 0xFF as follows: pulse all_ones; return audio state, sample_count and atten to reset values on the same edge.
REQ-026 SHALL give no event for any other opcode; undefined opcodes are not errors.
REQ-027 SHALL drive all outputs from registers.

Reset
REQ-028 SHALL, while rst_n=0, clear the byte counter, all pulses, audio_active, audio_22khz, sample_count, sample_data and every atten channel to 0, asynchronously.
REQ-029 SHALL discard any partial packet on reset mid-packet; the first byte after deassertion requires in_start.

Structure
REQ-030 SHALL place opcode constants (0xC4, 0xC5, 0xC7, 0x07, 0x0F, 0x17, 0x1F, 0xFF) and data1 constants (0xEF, 0x00) in a shared package.
REQ-031 SHALL contain one sub-module, op_byte_assembler: counter, framing, err_frame, and 24-bit packet plus one-cycle packet_valid.

Verification
REQ-032 SHALL cover: bytes 1F,00,00 with start on byte 0 -> audio_start=1, audio_active=1, audio_22khz=1 on the cycle after byte 3.
REQ-033 SHALL cover: 0F start, then C7,12,34 -> sample_valid pulse, sample_data=0x1234, sample_count=1; 07 -> audio_active=0.
REQ-034 SHALL cover: C4,5A,01 with NUM_ATTEN_CH=2 -> atten channel 1=0x5A; C4,77,02 -> atten unchanged.
REQ-035 SHALL cover: C5,EF then in_start on a new byte -> err_frame pulse, no power_on_r1; the following full C5,00,xx -> led_update.
REQ-036 SHALL cover: C7,AA,BB while inactive -> err_sample=1, sample_data unchanged; FF,FF,FF -> all_ones=1, atten cleared.
REQ-037 SHALL cover: SAMPLE_CNT_W=2 with five samples -> sample_count saturates at 3; rst_n low mid-packet -> all outputs 0 immediately.
